// File: rtl/mvm_input_loader.sv
// Streams a matrix A (row-major) followed by a vector B into their write ports,
// then holds calc_start until the MAC stage reports completion.
module mvm_input_loader #(
  parameter int NROWS_A = 4,
  parameter int NCOLS_A = 4,
  parameter int DATA_W  = 8,
  localparam int NA_ELEM = NROWS_A * NCOLS_A,
  localparam int AW = (NA_ELEM > 1) ? $clog2(NA_ELEM) : 1,
  localparam int BW = (NCOLS_A > 1) ? $clog2(NCOLS_A) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              a_wr_en,
  output logic [AW-1:0]     a_addr,
  output logic              b_wr_en,
  output logic [BW-1:0]     b_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              calc_start,
  input  logic              calc_done,
  output logic [7:0]        set_count
);

  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    FLUSH     = 2'd2,
    WAIT_CALC = 2'd3
  } state_t;

  localparam logic [AW-1:0] A_LAST = AW'(NA_ELEM - 1);
  localparam logic [AW-1:0] B_LAST = AW'(NCOLS_A - 1);

  state_t                   state_p0, state_nxt;
  logic [AW-1:0]            cnt_p0;
  logic                     hs_p0;
  logic                     a_vld_p1, b_vld_p1;
  logic [AW-1:0]            a_addr_p1;
  logic [BW-1:0]            b_addr_p1;
  logic signed [DATA_W-1:0] data_p1;
  logic [7:0]               set_cnt;

  assign s_ready = (state_p0 == LOAD_A) || (state_p0 == LOAD_B);
  assign hs_p0   = s_valid && s_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_p0 <= LOAD_A;
    else          state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      LOAD_A:    if (hs_p0 && cnt_p0 == A_LAST) state_nxt = LOAD_B;
      LOAD_B:    if (hs_p0 && cnt_p0 == B_LAST) state_nxt = FLUSH;
      FLUSH:     state_nxt = WAIT_CALC;
      WAIT_CALC: if (calc_done) state_nxt = LOAD_A;
      default:   state_nxt = LOAD_A;
    endcase
  end

  // p0 -> p1: element counter restarts on every state entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_p0    <= '0;
      a_vld_p1  <= 1'b0;
      b_vld_p1  <= 1'b0;
      a_addr_p1 <= '0;
      b_addr_p1 <= '0;
      data_p1   <= '0;
      set_cnt   <= 8'd0;
    end else begin
      a_vld_p1 <= hs_p0 && (state_p0 == LOAD_A);
      b_vld_p1 <= hs_p0 && (state_p0 == LOAD_B);
      if (state_nxt != state_p0) cnt_p0 <= '0;
      else if (hs_p0)            cnt_p0 <= cnt_p0 + 1'b1;
      if (hs_p0) data_p1 <= $signed(s_data);
      if (hs_p0 && state_p0 == LOAD_A) a_addr_p1 <= cnt_p0;
      if (hs_p0 && state_p0 == LOAD_B) b_addr_p1 <= cnt_p0[BW-1:0];
      if (state_p0 == WAIT_CALC && calc_done) set_cnt <= set_cnt + 8'd1;
    end
  end

  assign a_wr_en    = a_vld_p1;
  assign b_wr_en    = b_vld_p1;
  assign a_addr     = a_addr_p1;
  assign b_addr     = b_addr_p1;
  assign wr_data    = data_p1;
  assign calc_start = (state_p0 == WAIT_CALC);
  assign set_count  = set_cnt;

endmodule

// File: tb/tb_mvm_input_loader.sv
// Directed bench for mvm_input_loader: load sequencing, handshake, calc_done and reset behaviour.
module tb_mvm_input_loader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready;
  logic       a_wr_en, b_wr_en;
  logic [3:0] a_addr;
  logic [1:0] b_addr;
  logic [7:0] wr_data;
  logic       calc_start;
  logic       calc_done = 1'b0;
  logic [7:0] set_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int aq[$];
  int bq[$];
  int both_cnt = 0;
  int last_b_cyc = -1;
  int cs_rise_cyc = -1;
  logic cs_prev = 1'b0;

  mvm_input_loader #(.NROWS_A(4), .NCOLS_A(4), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .a_wr_en(a_wr_en), .a_addr(a_addr), .b_wr_en(b_wr_en),
    .b_addr(b_addr), .wr_data(wr_data), .calc_start(calc_start),
    .calc_done(calc_done), .set_count(set_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_wr_en) aq.push_back(int'(a_addr) * 256 + int'(wr_data));
    if (b_wr_en) begin
      bq.push_back(int'(b_addr) * 256 + int'(wr_data));
      last_b_cyc <= cyc;
    end
    if (a_wr_en && b_wr_en) both_cnt <= both_cnt + 1;
    if (calc_start && !cs_prev) cs_rise_cyc <= cyc;
    cs_prev <= calc_start;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the element was accepted.
  task automatic send(input logic [7:0] d);
    int n = 0;
    logic rdy;
    s_valid = 1'b1;
    s_data  = d;
    do begin
      rdy = s_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 100);
    if (!rdy) chk("send_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    aq.delete();
    bq.delete();
  endtask

  task automatic check_set(input string tag);
    chk({tag, "_a_count"}, aq.size(), 16);
    for (int i = 0; i < aq.size() && i < 16; i++)
      chk({tag, "_a_wr"}, aq[i], i * 256 + i + 1);
    chk({tag, "_b_count"}, bq.size(), 4);
    for (int j = 0; j < bq.size() && j < 4; j++)
      chk({tag, "_b_wr"}, bq[j], j * 256 + 17 + j);
  endtask

  task automatic wait_calc();
    int n = 0;
    while (!calc_start && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!calc_start) chk("calc_start_timeout", 0, 1);
  endtask

  task automatic pulse_done();
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
  endtask

  task automatic full_set();
    for (int i = 1; i <= 20; i++) send(8'(i));
    wait_calc();
    pulse_done();
  endtask

  initial begin
    int ready_hi;

    // asynchronous reset before any clock edge
    #3 reset_n = 1'b0;
    #1;
    chk("rst_a_wr_en", a_wr_en, 0);
    chk("rst_b_wr_en", b_wr_en, 0);
    chk("rst_calc_start", calc_start, 0);
    chk("rst_set_count", set_count, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_b_addr", b_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_s_ready", s_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // back-to-back load, with a calc_done pulse ignored during LOAD_B
    clear_log();
    for (int i = 1; i <= 17; i++) send(8'(i));
    calc_done = 1'b1;
    send(8'd18);
    calc_done = 1'b0;
    send(8'd19);
    send(8'd20);
    idle(3);
    check_set("b2b");
    chk("b2b_both_wr", both_cnt, 0);
    chk("b2b_calc_start_lat", cs_rise_cyc - last_b_cyc, 1);
    chk("b2b_calc_start", calc_start, 1);
    chk("b2b_s_ready", s_ready, 0);
    chk("loadb_done_ignored", set_count, 0);

    // calc_done accepted in WAIT_CALC with s_valid offered on the same edge
    clear_log();
    calc_done = 1'b1;
    s_valid = 1'b1;
    s_data = 8'd99;
    @(negedge clk);
    calc_done = 1'b0;
    s_valid = 1'b0;
    chk("done_calc_start", calc_start, 0);
    chk("done_set_count", set_count, 1);
    chk("done_s_ready", s_ready, 1);
    @(negedge clk);
    chk("done_no_write", aq.size(), 0);

    // bubbly input
    clear_log();
    for (int i = 1; i <= 20; i++) begin
      idle($urandom_range(0, 3));
      send(8'(i));
    end
    idle(3);
    check_set("bubbly");
    chk("bubbly_both_wr", both_cnt, 0);

    // stall in WAIT_CALC with s_valid held high
    clear_log();
    ready_hi = 0;
    s_valid = 1'b1;
    s_data = 8'd55;
    for (int c = 0; c < 50; c++) begin
      if (s_ready) ready_hi++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("stall_ready_cycles", ready_hi, 0);
    chk("stall_a_writes", aq.size(), 0);
    chk("stall_b_writes", bq.size(), 0);
    chk("stall_calc_start", calc_start, 1);
    pulse_done();
    chk("stall_set_count", set_count, 2);

    // reset after 10 A elements
    for (int i = 1; i <= 10; i++) send(8'(i));
    chk("pre_rst_a_wr_en", a_wr_en, 1);
    chk("pre_rst_a_addr", a_addr, 9);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_a_wr_en", a_wr_en, 0);
    chk("mid_rst_a_addr", a_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_set_count", set_count, 0);
    chk("mid_rst_s_ready", s_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    for (int i = 1; i <= 20; i++) send(8'(i));
    idle(3);
    check_set("post_rst");

    // wrap of set_count: the loaded set completes, then 255 more
    wait_calc();
    pulse_done();
    chk("wrap_first", set_count, 1);
    for (int s = 0; s < 255; s++) full_set();
    chk("wrap_256", set_count, 0);
    full_set();
    chk("wrap_257", set_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
